// File: rtl/encoder_circuit.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags.
// One clock of latency; PRIORITY_HIGH selects MSB-wins (1) or LSB-wins (0).
module encoder_circuit #(
   parameter int PRIORITY_HIGH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] d,
   output logic [2:0] a,
   output logic       valid,
   output logic       multi
);

   logic [2:0] w_idx;
   logic       w_any;
   logic [7:0] w_low_cleared;
   logic       w_multi;

   logic [2:0] r_a;
   logic       r_valid;
   logic       r_multi;

   // Later loop iterations overwrite earlier ones, so scan order sets the winner.
   always_comb begin
      w_idx = 3'd0;
      if (PRIORITY_HIGH != 0) begin
         for (int i = 0; i < 8; i++) begin
            if (d[i]) w_idx = 3'(i);
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (d[i]) w_idx = 3'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only when two or more were set.
   always_comb begin
      w_any         = |d;
      w_low_cleared = d & (d - 8'd1);
      w_multi       = |w_low_cleared;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= 3'd0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else begin
         r_a     <= w_idx;
         r_valid <= w_any;
         r_multi <= w_multi;
      end
   end

   assign a     = r_a;
   assign valid = r_valid;
   assign multi = r_multi;

endmodule

// File: tb/tb_encoder_circuit.sv
// Directed bench for encoder_circuit: both priority settings driven in parallel
// from one stimulus stream, expected values hand-computed in the vector tables.
module tb_encoder_circuit;

   logic       clk;
   logic       rst;
   logic [7:0] d;
   logic [2:0] a_hi, a_lo;
   logic       valid_hi, valid_lo, multi_hi, multi_lo;

   int checks   = 0;
   int failures = 0;

   encoder_circuit #(.PRIORITY_HIGH(1)) u_dut_hi (
      .clk(clk), .rst(rst), .d(d), .a(a_hi), .valid(valid_hi), .multi(multi_hi)
   );

   encoder_circuit #(.PRIORITY_HIGH(0)) u_dut_lo (
      .clk(clk), .rst(rst), .d(d), .a(a_lo), .valid(valid_lo), .multi(multi_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] ea_hi, input logic [2:0] ea_lo,
                          input logic ev, input logic em);
      chk({tag, " a_hi"},     8'(a_hi),     8'(ea_hi));
      chk({tag, " a_lo"},     8'(a_lo),     8'(ea_lo));
      chk({tag, " valid_hi"}, 8'(valid_hi), 8'(ev));
      chk({tag, " valid_lo"}, 8'(valid_lo), 8'(ev));
      chk({tag, " multi_hi"}, 8'(multi_hi), 8'(em));
      chk({tag, " multi_lo"}, 8'(multi_lo), 8'(em));
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
   task automatic apply(input logic [7:0] dv, input logic rv);
      d   = dv;
      rst = rv;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] mh_d   [6] = '{8'b00100100, 8'hFF, 8'b11000000, 8'b00000011, 8'b10000001, 8'b01011010};
   logic [2:0] mh_ahi [6] = '{3'd5,        3'd7,  3'd7,        3'd1,        3'd7,        3'd6};
   logic [2:0] mh_alo [6] = '{3'd2,        3'd0,  3'd6,        3'd0,        3'd0,        3'd1};

   initial begin
      rst = 1'b1;
      d   = 8'hFF;
      @(posedge clk);
      #1;

      // Reset held with all lines active
      apply(8'hFF, 1'b1);
      chk_all("rst0", 3'd0, 3'd0, 1'b0, 1'b0);
      apply(8'hFF, 1'b1);
      chk_all("rst1", 3'd0, 3'd0, 1'b0, 1'b0);
      apply(8'hFF, 1'b0);
      chk_all("rst_release", 3'd7, 3'd0, 1'b1, 1'b1);

      // One-hot sweep: index independent of priority
      for (int i = 0; i < 8; i++) begin
         apply(8'h01 << i, 1'b0);
         chk_all($sformatf("onehot%0d", i), 3'(i), 3'(i), 1'b1, 1'b0);
      end

      // Zero vs bit 0
      apply(8'h00, 1'b0);
      chk_all("zero", 3'd0, 3'd0, 1'b0, 1'b0);
      apply(8'h01, 1'b0);
      chk_all("bit0", 3'd0, 3'd0, 1'b1, 1'b0);

      // Multi-hot priority
      for (int i = 0; i < 6; i++) begin
         apply(mh_d[i], 1'b0);
         chk_all($sformatf("multi_%02h", mh_d[i]), mh_ahi[i], mh_alo[i], 1'b1, 1'b1);
      end

      // d changes between edges must not reach the outputs
      apply(8'b00010000, 1'b0);
      chk_all("pre_change", 3'd4, 3'd4, 1'b1, 1'b0);
      d = 8'hFF;
      #3;
      chk_all("mid_change", 3'd4, 3'd4, 1'b1, 1'b0);
      d = 8'h00;
      #3;
      chk_all("mid_change2", 3'd4, 3'd4, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk_all("after_change", 3'd0, 3'd0, 1'b0, 1'b0);

      // One-cycle reset in the middle of a one-hot sweep
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            apply(8'h01 << i, 1'b1);
            chk_all("sweep_rst", 3'd0, 3'd0, 1'b0, 1'b0);
         end else begin
            apply(8'h01 << i, 1'b0);
            chk_all($sformatf("sweep%0d", i), 3'(i), 3'(i), 1'b1, 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/encoder_circuit.md
# encoder_circuit

Registered 8-to-3 priority encoder with valid and multi-hot flags. It converts an 8-bit request/one-hot vector into the 3-bit index of the selected active bit. It also reports whether any bit was active and whether more than one was. It sits between a request/status vector and downstream index-consuming logic, and provides one clock of pipelining.

## Interface
Parameters:
- PRIORITY_HIGH, default 1: 1 = highest-index set bit wins; 0 = lowest-index set bit wins.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- d    input  8  input vector; bit i set = request/line i active.
- a    output 3  encoded index of the selected set bit of d (registered).
- valid output 1  1 when at least one bit of d was set (registered).
- multi output 1  1 when two or more bits of d were set (registered).

## Operation
- Each rising clk edge with rst=0 samples d and registers three results:
  - a: the encoded index of the winning bit.
  - valid: the OR of all bits of d.
  - multi: 1 when the population count of d is at least 2.
- Winner selection:
  - PRIORITY_HIGH=1: a = index of the most significant set bit.
  - PRIORITY_HIGH=0: a = index of the least significant set bit.
- One-hot input: a = position of the set bit, independent of PRIORITY_HIGH; valid=1, multi=0.
  - 8'b00000001 -> 0; 8'b00000010 -> 1; 8'b00000100 -> 2; 8'b00001000 -> 3.
  - 8'b00010000 -> 4; 8'b00100000 -> 5; 8'b01000000 -> 6; 8'b10000000 -> 7.
- All-zero input: a=3'b000, valid=0, multi=0. Consumers must qualify a with valid, because d=0 and d=8'b00000001 both give a=0.
- Multi-hot input: a follows the priority rule and multi=1.
  - d=8'hFF gives a=7 for PRIORITY_HIGH=1, a=0 for PRIORITY_HIGH=0.
- d is treated as exactly 8 bits. A driver assigning a wider constant gets standard Verilog truncation to the low 8 bits (9'h1FF arrives as 8'hFF).
- Pure datapath: no FSM, no internal state other than the output registers.

## Timing
- Latency is 1 cycle: the outputs reflect the d sampled at edge N, visible after edge N until edge N+1.
- Throughput: one new input per cycle; no handshake and no stall.
- Reset (rst=1 at a rising edge): a=3'b000, valid=0, multi=0 from that edge on.
  - Reset overrides d.
  - rst asserted mid-stream discards the sample taken at that edge.
  - The first sample after reset deassertion is the d present at the first edge with rst=0.
- Before the first reset, outputs are undefined (X in simulation). The bench must reset first.
- d changing between edges has no effect on the outputs until the next edge. There is no combinational path from d to any output.

## Test plan
- Reset: drive rst=1 for 2 cycles with d=8'hFF -> a=0, valid=0, multi=0 throughout; release rst -> next edge a=7, valid=1, multi=1 (PRIORITY_HIGH=1).
- One-hot sweep: apply d=1<<i for i=0..7, one per cycle -> one cycle later a=i, valid=1, multi=0 each cycle, for both PRIORITY_HIGH values.
- Zero input: d=8'h00 -> a=0, valid=0, multi=0; then d=8'h01 -> a=0, valid=1, distinguishing the two cases.
- Multi-hot priority, PRIORITY_HIGH=1:
  - d=8'b00100100 -> a=5, multi=1.
  - d=8'hFF -> a=7, multi=1.
- Multi-hot priority, PRIORITY_HIGH=0:
  - d=8'b00100100 -> a=2, multi=1.
  - d=8'hFF -> a=0, multi=1.
- Mid-stream reset and latency: change d between edges -> outputs unchanged until next edge; assert rst for one cycle during a one-hot sweep -> that cycle's outputs are 0/0/0, and the sweep resumes correctly the following cycle.
